amo_rmw_unit: RTL and testbench



---
 rtl/amo_rmw_unit.sv | 212 +++++++++++++++++++++
 tb/tb_amo_rmw_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_rmw_unit.sv
// amo_rmw_unit: sequential atomic read-modify-write engine.
// Reads a word from the data array, applies an AMO at 32-bit or full width,
// writes the lane back under a byte mask and returns the old value.
`timescale 1ns/1ps
module amo_rmw_unit #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_cmd,
  input  logic [1:0]            req_size,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(STRB_W - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_CALC    = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [4:0] CMD_SWAP = 5'h04;
  localparam logic [4:0] CMD_ADD  = 5'h08;
  localparam logic [4:0] CMD_XOR  = 5'h09;
  localparam logic [4:0] CMD_OR   = 5'h0a;
  localparam logic [4:0] CMD_AND  = 5'h0b;
  localparam logic [4:0] CMD_MIN  = 5'h0c;
  localparam logic [4:0] CMD_MAX  = 5'h0d;
  localparam logic [4:0] CMD_MINU = 5'h0e;
  localparam logic [4:0] CMD_MAXU = 5'h0f;

  logic [2:0]        state;
  logic [2:0]        state_nxt;

  // Latched request and captured read data
  logic [4:0]        cmd_q;
  logic              is_word_q;
  logic              lane_q;
  logic [DATA_W-1:0] rhs_q;
  logic [DATA_W-1:0] rdata_q;

  logic              fire;
  logic              cmd_ok;
  logic              size_ok;
  logic              align_ok;
  logic              req_legal;

  logic [31:0]       lhs32;
  logic [DATA_W-1:0] lhs_s;
  logic [DATA_W-1:0] rhs_s;
  logic [DATA_W-1:0] lhs_u;
  logic [DATA_W-1:0] rhs_u;
  logic              lhs_lt_s;
  logic              rhs_lt_s;
  logic              lhs_lt_u;
  logic              rhs_lt_u;
  logic [DATA_W-1:0] res_c;
  logic [DATA_W-1:0] wdata_c;
  logic [STRB_W-1:0] wmask_c;
  logic [DATA_W-1:0] old_c;

  assign fire = req_valid & req_ready;

  // Request legality: supported command, supported size, natural alignment
  always_comb begin
    cmd_ok = 1'b0;
    case (req_cmd)
      CMD_SWAP, CMD_ADD, CMD_XOR, CMD_OR, CMD_AND,
      CMD_MIN, CMD_MAX, CMD_MINU, CMD_MAXU: cmd_ok = 1'b1;
      default: cmd_ok = 1'b0;
    endcase
    size_ok   = (req_size == 2'd2) || ((req_size == 2'd3) && (DATA_W == 64));
    align_ok  = (req_size == 2'd3) ? (req_addr[2:0] == 3'd0) : (req_addr[1:0] == 2'd0);
    req_legal = cmd_ok & size_ok & align_ok;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (fire) state_nxt = req_legal ? S_RD_REQ : S_RESP;
      S_RD_REQ:  if (mem_req_ready) state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_resp_valid) state_nxt = S_CALC;
      S_CALC:    state_nxt = S_WR_REQ;
      S_WR_REQ:  if (mem_req_ready) state_nxt = S_RESP;
      S_RESP:    if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Operand extraction and AMO arithmetic at operand width
  always_comb begin
    lhs32 = 32'(rdata_q >> {lane_q, 5'd0});
    if (is_word_q) begin
      lhs_s = DATA_W'($signed(lhs32));
      rhs_s = DATA_W'($signed(rhs_q[31:0]));
      lhs_u = DATA_W'(lhs32);
      rhs_u = DATA_W'(rhs_q[31:0]);
    end else begin
      lhs_s = rdata_q;
      rhs_s = rhs_q;
      lhs_u = rdata_q;
      rhs_u = rhs_q;
    end

    lhs_lt_s = $signed(lhs_s) < $signed(rhs_s);
    rhs_lt_s = $signed(rhs_s) < $signed(lhs_s);
    lhs_lt_u = lhs_u < rhs_u;
    rhs_lt_u = rhs_u < lhs_u;

    res_c = lhs_u;
    case (cmd_q)
      CMD_SWAP: res_c = rhs_u;
      CMD_ADD:  res_c = lhs_u + rhs_u;
      CMD_XOR:  res_c = lhs_u ^ rhs_u;
      CMD_OR:   res_c = lhs_u | rhs_u;
      CMD_AND:  res_c = lhs_u & rhs_u;
      CMD_MIN:  res_c = rhs_lt_s ? rhs_u : lhs_u;
      CMD_MAX:  res_c = lhs_lt_s ? rhs_u : lhs_u;
      CMD_MINU: res_c = rhs_lt_u ? rhs_u : lhs_u;
      CMD_MAXU: res_c = lhs_lt_u ? rhs_u : lhs_u;
      default:  res_c = lhs_u;
    endcase

    // Word results are placed back into their lane; carries never leave it
    if (is_word_q) begin
      wdata_c = DATA_W'(res_c[31:0]) << {lane_q, 5'd0};
      wmask_c = STRB_W'(4'hF) << {lane_q, 2'b00};
      old_c   = lhs_s;
    end else begin
      wdata_c = res_c;
      wmask_c = '1;
      old_c   = rdata_q;
    end
  end

  // Registered outputs and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      cmd_q         <= '0;
      is_word_q     <= 1'b0;
      lane_q        <= 1'b0;
      rhs_q         <= '0;
      rdata_q       <= '0;
    end else begin
      req_ready     <= (state_nxt == S_IDLE);
      mem_req_valid <= (state_nxt == S_RD_REQ) || (state_nxt == S_WR_REQ);
      mem_req_write <= (state_nxt == S_WR_REQ);
      resp_valid    <= (state_nxt == S_RESP);

      if (fire) begin
        cmd_q         <= req_cmd;
        is_word_q     <= (req_size == 2'd2);
        lane_q        <= req_addr[2] & (DATA_W == 64);
        rhs_q         <= req_data;
        mem_req_addr  <= req_addr & ADDR_MASK;
        mem_req_wdata <= '0;
        mem_req_wmask <= '0;
        resp_data     <= '0;
        resp_err      <= ~req_legal;
      end

      if ((state == S_RD_WAIT) && mem_resp_valid) begin
        rdata_q <= mem_resp_data;
      end

      if (state == S_CALC) begin
        mem_req_wdata <= wdata_c;
        mem_req_wmask <= wmask_c;
        resp_data     <= old_c;
      end
    end
  end

endmodule

// File: tb/tb_amo_rmw_unit.sv
// tb_amo_rmw_unit: directed scoreboard bench for amo_rmw_unit with a small memory model.
`timescale 1ns/1ps
module tb_amo_rmw_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_cmd;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } exp_t;

  typedef struct {
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         obs_wr_q[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] mem [0:7];
  int          rd_cnt;
  int          wr_cnt;
  int          mreq_cnt;
  int          mresp_cnt;
  int          mem_resp_delay;

  always #5 clock = ~clock;

  amo_rmw_unit #(.DATA_W(64), .ADDR_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_err       (resp_err)
  );

  function automatic logic [63:0] byte_mask(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r[i*8 +: 8] = 8'hFF;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Memory model: samples fires at negedge, returns read data after mem_resp_delay cycles
  initial begin : mem_model
    int          pend;
    logic [2:0]  rd_idx;
    logic [2:0]  idx;
    logic [63:0] bm;
    wr_t         w;
    mem[0] = 64'h00000005_FFFFFFFF;
    mem[1] = 64'hFFFFFFFF_FFFFFFFF;
    mem[2] = 64'hFFFFFFFF_FFFFFFFF;
    mem[3] = 64'hFFFFFFFF_FFFFFFFF;
    mem[4] = 64'h11223344_55667788;
    mem[5] = 64'h80000000_7FFFFFFF;
    mem[6] = 64'h01234567_89ABCDEF;
    mem[7] = 64'hF0F0F0F0_0F0F0F0F;
    pend = -1;
    rd_idx = '0;
    rd_cnt = 0;
    wr_cnt = 0;
    mreq_cnt = 0;
    mresp_cnt = 0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clock);
      if (mem_req_valid) mreq_cnt++;
      if (mem_req_valid && mem_req_ready) begin
        idx = mem_req_addr[5:3];
        if (mem_req_write) begin
          bm = byte_mask(mem_req_wmask);
          mem[idx] = (mem[idx] & ~bm) | (mem_req_wdata & bm);
          w.wmask = mem_req_wmask;
          w.wdata = mem_req_wdata & bm;
          obs_wr_q.push_back(w);
          wr_cnt++;
        end else begin
          rd_cnt++;
          rd_idx = idx;
          pend = mem_resp_delay;
        end
      end
      @(posedge clock);
      #1;
      mem_resp_valid = 1'b0;
      if (pend == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = mem[rd_idx];
        mresp_cnt++;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
    end
  end

  // One complete request: drive, wait for response, check against the scoreboard
  task automatic do_req(input string tag, input logic [4:0] cmd, input logic [1:0] size,
                        input logic [31:0] addr, input logic [63:0] rhs,
                        input logic [63:0] exp_data, input logic exp_err,
                        input logic [7:0] exp_wmask, input logic [63:0] exp_wdata,
                        input int exp_lat);
    exp_t e;
    wr_t  w;
    int   n;
    int   rd0;
    int   wr0;
    int   mq0;
    e.data = exp_data;
    e.err = exp_err;
    e.wmask = exp_wmask;
    e.wdata = exp_wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1'b1));
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    mq0 = mreq_cnt;
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_cmd = cmd;
    req_size = size;
    req_addr = addr;
    req_data = rhs;
    cyc();
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 50) begin
      cyc();
      n++;
    end
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(1'b1));
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    e = exp_q.pop_front();
    chk({tag, "_resp_data"}, resp_data, e.data);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'(e.err));
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    chk({tag, "_resp_drop"}, 64'(resp_valid), 64'(1'b0));
    chk({tag, "_reads"}, 64'(rd_cnt - rd0), e.err ? 64'd0 : 64'd1);
    chk({tag, "_writes"}, 64'(wr_cnt - wr0), e.err ? 64'd0 : 64'd1);
    if (e.err) begin
      chk({tag, "_no_mem_req"}, 64'(mreq_cnt - mq0), 64'd0);
    end else if (obs_wr_q.size() > 0) begin
      w = obs_wr_q.pop_front();
      chk({tag, "_wmask"}, 64'(w.wmask), 64'(e.wmask));
      chk({tag, "_wdata"}, w.wdata, e.wdata);
    end
  endtask

  initial begin : main
    exp_t e;
    wr_t  w;
    int   n;
    int   rd0;
    int   wr0;
    int   rs0;

    reset = 1'b1;
    req_valid = 1'b0;
    req_cmd = '0;
    req_size = '0;
    req_addr = '0;
    req_data = '0;
    mem_req_ready = 1'b1;
    resp_ready = 1'b0;
    mem_resp_delay = 0;
    repeat (3) cyc();

    chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(1'b0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(1'b0));
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'(1'b0));
    reset = 1'b0;
    cyc();

    do_req("add_hi",  5'h08, 2'd2, 32'h04, 64'h00000000_FFFFFFFF,
           64'h00000000_00000005, 1'b0, 8'hF0, 64'h00000004_00000000, 5);
    do_req("add_lo",  5'h08, 2'd2, 32'h00, 64'h1,
           64'hFFFFFFFF_FFFFFFFF, 1'b0, 8'h0F, 64'h0, 5);
    do_req("min_s",   5'h0c, 2'd3, 32'h08, 64'h1,
           64'hFFFFFFFF_FFFFFFFF, 1'b0, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 5);
    do_req("minu",    5'h0e, 2'd3, 32'h10, 64'h1,
           64'hFFFFFFFF_FFFFFFFF, 1'b0, 8'hFF, 64'h1, 5);
    do_req("maxu",    5'h0f, 2'd3, 32'h18, 64'h1,
           64'hFFFFFFFF_FFFFFFFF, 1'b0, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 5);
    do_req("max_w",   5'h0d, 2'd2, 32'h28, 64'h80000000,
           64'h00000000_7FFFFFFF, 1'b0, 8'h0F, 64'h00000000_7FFFFFFF, 5);
    do_req("xor_hi",  5'h09, 2'd2, 32'h2C, 64'h0000FFFF,
           64'hFFFFFFFF_80000000, 1'b0, 8'hF0, 64'h8000FFFF_00000000, 5);
    do_req("minu_hi", 5'h0e, 2'd2, 32'h2C, 64'h7,
           64'hFFFFFFFF_8000FFFF, 1'b0, 8'hF0, 64'h00000007_00000000, 5);
    do_req("or_d",    5'h0a, 2'd3, 32'h38, 64'h0000FFFF_0000FFFF,
           64'hF0F0F0F0_0F0F0F0F, 1'b0, 8'hFF, 64'hF0F0FFFF_0F0FFFFF, 5);
    do_req("and_d",   5'h0b, 2'd3, 32'h38, 64'hFF00FF00_FF00FF00,
           64'hF0F0FFFF_0F0FFFFF, 1'b0, 8'hFF, 64'hF000FF00_0F00FF00, 5);

    do_req("ill_cmd",   5'h00, 2'd3, 32'h28, 64'h1, 64'h0, 1'b1, 8'h0, 64'h0, 1);
    do_req("ill_align", 5'h04, 2'd3, 32'h04, 64'h1, 64'h0, 1'b1, 8'h0, 64'h0, 1);
    do_req("ill_mis_w", 5'h08, 2'd2, 32'h02, 64'h1, 64'h0, 1'b1, 8'h0, 64'h0, 1);
    do_req("ill_size",  5'h08, 2'd1, 32'h00, 64'h1, 64'h0, 1'b1, 8'h0, 64'h0, 1);

    // Backpressure on read, write and response
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    e.data = 64'h11223344_55667788;
    e.err = 1'b0;
    e.wmask = 8'hFF;
    e.wdata = 64'hA5A5A5A5_A5A5A5A5;
    exp_q.push_back(e);
    mem_req_ready = 1'b0;
    req_valid = 1'b1;
    req_cmd = 5'h04;
    req_size = 2'd3;
    req_addr = 32'h20;
    req_data = 64'hA5A5A5A5_A5A5A5A5;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rd_valid", 64'(mem_req_valid), 64'(1'b1));
      chk("bp_rd_write", 64'(mem_req_write), 64'(1'b0));
      chk("bp_rd_addr", 64'(mem_req_addr), 64'h20);
      chk("bp_rd_wmask", 64'(mem_req_wmask), 64'h0);
      chk("bp_rd_busy", 64'(req_ready), 64'(1'b0));
      cyc();
    end
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    n = 0;
    while (!(mem_req_valid && mem_req_write) && n < 20) begin
      chk("bp_wait_busy", 64'(req_ready), 64'(1'b0));
      cyc();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_wr_valid", 64'(mem_req_valid), 64'(1'b1));
      chk("bp_wr_write", 64'(mem_req_write), 64'(1'b1));
      chk("bp_wr_addr", 64'(mem_req_addr), 64'h20);
      chk("bp_wr_wmask", 64'(mem_req_wmask), 64'hFF);
      chk("bp_wr_wdata", mem_req_wdata, 64'hA5A5A5A5_A5A5A5A5);
      chk("bp_wr_busy", 64'(req_ready), 64'(1'b0));
      cyc();
    end
    mem_req_ready = 1'b1;
    cyc();
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++) begin
      chk("bp_resp_valid", 64'(resp_valid), 64'(1'b1));
      chk("bp_resp_data", resp_data, e.data);
      chk("bp_resp_err", 64'(resp_err), 64'(e.err));
      chk("bp_resp_busy", 64'(req_ready), 64'(1'b0));
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    chk("bp_resp_drop", 64'(resp_valid), 64'(1'b0));
    chk("bp_idle_ready", 64'(req_ready), 64'(1'b1));
    chk("bp_reads", 64'(rd_cnt - rd0), 64'd1);
    chk("bp_writes", 64'(wr_cnt - wr0), 64'd1);
    chk("bp_wr_logged", 64'(obs_wr_q.size()), 64'd1);
    if (obs_wr_q.size() > 0) begin
      w = obs_wr_q.pop_front();
      chk("bp_wmask", 64'(w.wmask), 64'(e.wmask));
      chk("bp_wdata", w.wdata, e.wdata);
    end

    // Reset while waiting for read data; the late response must be ignored
    mem_resp_delay = 4;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    rs0 = mresp_cnt;
    req_valid = 1'b1;
    req_cmd = 5'h08;
    req_size = 2'd3;
    req_addr = 32'h30;
    req_data = 64'h1;
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (rd_cnt == rd0 && n < 20) begin
      cyc();
      n++;
    end
    chk("rst_rd_fired", 64'(rd_cnt - rd0), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_mem_valid", 64'(mem_req_valid), 64'(1'b0));
    chk("rst_async_resp_valid", 64'(resp_valid), 64'(1'b0));
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rst_quiet_resp", 64'(resp_valid), 64'(1'b0));
      chk("rst_quiet_mem", 64'(mem_req_valid), 64'(1'b0));
      cyc();
    end
    chk("rst_stale_sent", 64'(mresp_cnt - rs0), 64'd1);
    chk("rst_no_write", 64'(wr_cnt - wr0), 64'd0);
    mem_resp_delay = 0;
    do_req("swap_post_rst", 5'h04, 2'd3, 32'h30, 64'hDEADBEEF_CAFEF00D,
           64'h01234567_89ABCDEF, 1'b0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
